// File: rtl/lsu_ctrl_pkg.sv
// Shared decoder definitions: access size codes, LSU FSM states, legality check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lsu_ctrl_pkg;

  // Access size codes as produced by the core decoder.
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // Load/store controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // An access is legal when the size code exists and the address is
  // naturally aligned for that size.
  function automatic logic lsu_access_legal(input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_B, SZ_BU: ok = 1'b1;
      SZ_H, SZ_HU: ok = ~addr_lo[0];
      SZ_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane formatting: byte enables, store lane replication, load extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides when the outputs are used.
module lsu_data_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_rd,
  output logic [3:0]  o_be,
  output logic [31:0] o_wd,
  output logic [31:0] o_rd
);

  logic [31:0] w_rd_shift;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;

  // Byte lane selected by the low address bits; halfword by addr[1].
  assign w_rd_shift = i_rd >> {i_addr_lo, 3'b000};
  assign w_rd_byte  = w_rd_shift[7:0];
  assign w_rd_half  = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];

  // Store side: which lanes are written and the replicated store data.
  always_comb begin
    o_be = 4'b0000;
    o_wd = 32'h0000_0000;
    case (i_size)
      SZ_B, SZ_BU: begin
        o_be = 4'b0001 << i_addr_lo;
        o_wd = {4{i_wd[7:0]}};
      end
      SZ_H, SZ_HU: begin
        o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wd = {2{i_wd[15:0]}};
      end
      SZ_W: begin
        o_be = 4'b1111;
        o_wd = i_wd;
      end
      default: begin
        o_be = 4'b0000;
        o_wd = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed lane(s) and sign- or zero-extend.
  always_comb begin
    o_rd = 32'h0000_0000;
    case (i_size)
      SZ_B:    o_rd = {{24{w_rd_byte[7]}}, w_rd_byte};
      SZ_BU:   o_rd = {24'h00_0000, w_rd_byte};
      SZ_H:    o_rd = {{16{w_rd_half[15]}}, w_rd_half};
      SZ_HU:   o_rd = {16'h0000, w_rd_half};
      SZ_W:    o_rd = i_rd;
      default: o_rd = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: latches a core access, issues it on the ready-handshaked bus.
// Latency: 3 cycles minimum (IDLE, BUSY with ready, DONE) plus one per bus wait state.
// Backpressure: core is stalled while a legal access is pending; bus stalls via mem_ready_i; optional timeout abort.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_size;
  logic [1:0]    r_addr_lo;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wd;
  logic [31:0]   r_rd;
  logic          r_err;

  logic          w_legal;
  logic          w_timeout;
  logic          w_idle;
  logic [2:0]    w_fmt_size;
  logic [1:0]    w_fmt_addr_lo;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_rd_ext;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_legal = lsu_access_legal(core_size_i, core_addr_i[1:0]);

  // Abort only when enabled and the last allowed BUSY cycle passes without ready.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

  // In IDLE the formatter sees the incoming access (store side); afterwards it
  // sees the latched access so the returning word is extended correctly.
  assign w_fmt_size    = w_idle ? core_size_i : r_size;
  assign w_fmt_addr_lo = w_idle ? core_addr_i[1:0] : r_addr_lo;

  lsu_data_align u_align (
    .i_size    (w_fmt_size),
    .i_addr_lo (w_fmt_addr_lo),
    .i_wd      (core_wd_i),
    .i_rd      (mem_rd_i),
    .o_be      (w_be),
    .o_wd      (w_wd),
    .o_rd      (w_rd_ext)
  );

  // Stall immediately on a legal request and hold it for the whole bus transaction.
  assign core_stall_o = ~rst_i &
                        ((r_state == ST_BUSY) | (w_idle & core_req_i & w_legal));

  assign core_rd_o  = r_rd;
  assign lsu_err_o  = r_err;
  assign mem_req_o  = r_mem_req;
  assign mem_we_o   = r_mem_we;
  assign mem_be_o   = r_mem_be;
  assign mem_addr_o = r_mem_addr;
  assign mem_wd_o   = r_mem_wd;

  // Access sequencing: accept in IDLE, wait for ready or timeout in BUSY, present data in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_size     <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= 4'b0000;
      r_mem_addr <= 32'h0000_0000;
      r_mem_wd   <= 32'h0000_0000;
      r_rd       <= 32'h0000_0000;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (core_req_i) begin
            if (w_legal) begin
              r_size     <= core_size_i;
              r_addr_lo  <= core_addr_i[1:0];
              r_mem_req  <= 1'b1;
              r_mem_we   <= core_we_i;
              r_mem_be   <= w_be;
              r_mem_addr <= {core_addr_i[31:2], 2'b00};
              r_mem_wd   <= w_wd;
              r_cnt      <= '0;
              r_state    <= ST_BUSY;
            end else begin
              // Misaligned or unknown size: never reaches the bus.
              r_err <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready_i) begin
            r_rd      <= w_rd_ext;
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Core consumes core_rd_o and advances at the end of this cycle.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
